gerador_janela: RTL and testbench
=================================

# gerador_janela

Streaming 3x3 window generator feeding the convolution stage. Accepts one 8-bit grayscale pixel per cycle in raster order. Buffers the two previous image lines internally. For every accepted pixel that completes a full 3x3 neighbourhood, emits that neighbourhood packed into a 72-bit word with a valid strobe. This is exactly the `pixel_data_in` / `pixel_data_valid_in` format the convolver consumes.

## Interface
- `IMG_WIDTH`, default 160: pixels per line. Minimum 3.
- `IMG_HEIGHT`, default 120: lines per frame. Minimum 3.
- `clk_in` (in, 1): single clock; all logic on its rising edge.
- `reset_n_in` (in, 1): asynchronous, active-low reset.
- `pixel_in` (in, 8): incoming pixel, raster order, left-to-right then top-to-bottom.
- `pixel_valid_in` (in, 1): `pixel_in` is accepted on every cycle this is high. There is no backpressure.
- `sof_in` (in, 1): start of frame. Exists only with `GERADOR_SOF_EN`.
- `window_out` (out, 72): 3x3 window. Byte `i` (bits `[i*8 +: 8]`) is position `i` in row-major order: 0 = top-left, 4 = centre, 8 = bottom-right.
- `window_valid_out` (out, 1): `window_out` is valid this cycle; one-cycle strobe per window.

## Operation
- Column counter `col` runs 0..`IMG_WIDTH`-1; row counter `row` runs 0..`IMG_HEIGHT`-1. Both advance only on accepted pixels.
- At `col` = `IMG_WIDTH`-1, `col` wraps to 0 and `row` increments.
- At the last pixel of the frame, both counters wrap to 0. The next accepted pixel is (0,0) of a new frame.
- Line buffer: depth `IMG_WIDTH`, 16 bits wide. Entry `col` holds {pixel(row-2,col), pixel(row-1,col)}.
- Buffer access on an accepted pixel, at address `col`:
  - read the old entry;
  - write {old[7:0], `pixel_in`}.
  - Read-before-write at the same address in the same cycle is required.
- Window shift register: three columns of three bytes. On each accepted pixel, shift one column left and load the new right column {row-2, row-1, current} = {old[15:8], old[7:0], `pixel_in`}.
- Window emission: an accepted pixel at (`row`,`col`) with `row`≥2 and `col`≥2 produces a window centred at (`row`-1,`col`-1).
- No border padding. Each frame yields exactly (`IMG_WIDTH`-2)·(`IMG_HEIGHT`-2) windows.
- Windows never straddle lines. Columns 0 and 1 of each line only prime the shift register.
- Windows never straddle frames. Rows 0 and 1 of a frame emit nothing, even though the buffer still holds data from the previous frame.
- Idle cycles (`pixel_valid_in` low) stall everything:
  - counters, buffer and shift register unchanged;
  - `window_valid_out` low;
  - `window_out` holds its last value.

## Timing
- Latency: `window_valid_out` and `window_out` are registered. They are asserted on the cycle after the rising edge that accepted the completing pixel.
- Throughput: one window per cycle sustained.
- Reset (asynchronous, immediate):
  - `window_out` = 0, `window_valid_out` = 0;
  - `col` = 0, `row` = 0;
  - shift register = 0;
  - line buffer contents not reset (don't care).
- Reset mid-frame: the next accepted pixel is treated as (0,0).
- Back-to-back frames need no gap cycles.
- Counter widths: `$clog2(IMG_WIDTH)` and `$clog2(IMG_HEIGHT)`, minimum 1.

## Configuration
- `GERADOR_SOF_EN` defined: adds port `sof_in`.
  - When `sof_in` and `pixel_valid_in` are both high, that pixel is forced to (0,0).
  - Counters restart from there; the shift register is not cleared.
  - `sof_in` while `pixel_valid_in` is low is ignored.
  - Re-synchronises after dropped or extra pixels.
- Not defined: no `sof_in` port. Framing relies solely on counter wrap after `IMG_WIDTH`·`IMG_HEIGHT` accepted pixels.

## Structure
- Package `gerador_janela_pkg`:
  - `PIXEL_W` = 8, `WIN_TAPS` = 9, `WIN_W` = 72;
  - typedef `pixel_t` (8-bit);
  - constants for tap indices (top-left 0, centre 4, bottom-right 8).
- Sub-module `linha_buffer`: parameterised `IMG_WIDTH`×16 RAM with synchronous write and read-before-write port, inferable as block RAM. The top level holds counters, shift register and output registers.

## Test plan
All scenarios use `IMG_WIDTH`=4, `IMG_HEIGHT`=4, pixel(r,c) = 4r+c+1.
- Continuous frame after reset:
  - exactly 4 strobes;
  - first window bytes 0..8 = 1,2,3,5,6,7,9,10,11;
  - last window = 6,7,8,10,11,12,14,15,16.
- Strobe timing:
  - no `window_valid_out` during rows 0–1 or columns 0–1;
  - first strobe exactly one cycle after pixel 11 (r2,c2) is accepted.
- Random idle cycles between pixels: same 4 windows in the same order; `window_out` stable while idle.
- Two frames back-to-back (second frame values +100): frame 2 emits 4 windows; its first window = 101,102,103,105,106,107,109,110,111. No window mixes frame-1 data.
- Assert `reset_n_in` low after pixel 9, then resend a full frame: outputs clear to 0 asynchronously; the subsequent frame produces the windows of the first scenario.
- `GERADOR_SOF_EN` defined: send 5 pixels of garbage, then a frame with `sof_in` on its first pixel. The 4 windows match the first scenario exactly.

Source files
------------

// File: rtl/gerador_janela_pkg.sv
// rtl/gerador_janela_pkg.sv - shared widths, types and tap indices for the 3x3 window generator
package gerador_janela_pkg;

  localparam int PIXEL_W  = 8;
  localparam int WIN_TAPS = 9;
  localparam int WIN_W    = PIXEL_W * WIN_TAPS;
  localparam int LINE_W   = 2 * PIXEL_W;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Row-major tap positions inside the packed window word
  localparam int TAP_TOP_LEFT     = 0;
  localparam int TAP_TOP_RIGHT    = 2;
  localparam int TAP_MID_RIGHT    = 5;
  localparam int TAP_CENTRE       = 4;
  localparam int TAP_BOTTOM_RIGHT = 8;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/linha_buffer.sv
// rtl/linha_buffer.sv - one-line RAM holding the two previous image rows per column
module linha_buffer #(
  parameter int DEPTH = 160,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:DEPTH-1];

  // Registered read returns the pre-write contents when both ports hit one address
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/gerador_janela.sv
// rtl/gerador_janela.sv - streaming 3x3 window generator; GERADOR_SOF_EN adds the sof_in frame-sync port
module gerador_janela
  import gerador_janela_pkg::*;
#(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  pixel_t           pixel_in,
  input  logic             pixel_valid_in,
`ifdef GERADOR_SOF_EN
  input  logic             sof_in,
`endif
  output logic [WIN_W-1:0] window_out,
  output logic             window_valid_out
);

  localparam int CW = cnt_width(IMG_WIDTH);
  localparam int RW = cnt_width(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(2);
  localparam logic [RW-1:0] ROW_WIN  = RW'(2);

  logic [CW-1:0]     col, col_cur, col_nxt, rd_addr;
  logic [RW-1:0]     row, row_cur, row_nxt;
  logic              accept, sof_hit, emit;
  logic [LINE_W-1:0] old_entry, new_entry;
  logic [WIN_W-1:0]  win_q, win_nxt;

  assign accept = pixel_valid_in;

`ifdef GERADOR_SOF_EN
  assign sof_hit = pixel_valid_in & sof_in;
`else
  assign sof_hit = 1'b0;
`endif

  always_comb begin
    col_cur = sof_hit ? '0 : col;
    row_cur = sof_hit ? '0 : row;
    if (col_cur == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
    end else begin
      col_nxt = col_cur + 1'b1;
      row_nxt = row_cur;
    end
    // Prefetch the entry for the next accepted pixel so it is ready on its edge
    rd_addr = accept ? col_nxt : col;
    emit    = accept && (row_cur >= ROW_WIN) && (col_cur >= COL_WIN);
  end

  assign new_entry = {old_entry[PIXEL_W-1:0], pixel_in};

  linha_buffer #(
    .DEPTH (IMG_WIDTH),
    .AW    (CW),
    .DW    (LINE_W)
  ) u_linha (
    .clk     (clk_in),
    .wr_en   (accept),
    .wr_addr (col_cur),
    .wr_data (new_entry),
    .rd_addr (rd_addr),
    .rd_data (old_entry)
  );

  always_comb begin
    win_nxt = win_q;
    for (int r = 0; r < 3; r++) begin
      win_nxt[(r*3 + 0)*PIXEL_W +: PIXEL_W] = win_q[(r*3 + 1)*PIXEL_W +: PIXEL_W];
      win_nxt[(r*3 + 1)*PIXEL_W +: PIXEL_W] = win_q[(r*3 + 2)*PIXEL_W +: PIXEL_W];
    end
    win_nxt[TAP_TOP_RIGHT*PIXEL_W    +: PIXEL_W] = old_entry[LINE_W-1 -: PIXEL_W];
    win_nxt[TAP_MID_RIGHT*PIXEL_W    +: PIXEL_W] = old_entry[PIXEL_W-1:0];
    win_nxt[TAP_BOTTOM_RIGHT*PIXEL_W +: PIXEL_W] = pixel_in;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      col              <= '0;
      row              <= '0;
      win_q            <= '0;
      window_out       <= '0;
      window_valid_out <= 1'b0;
    end else begin
      window_valid_out <= emit;
      if (accept) begin
        col   <= col_nxt;
        row   <= row_nxt;
        win_q <= win_nxt;
      end
      if (emit) begin
        window_out <= win_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gerador_janela.sv
// tb/tb_gerador_janela.sv - self-checking bench for gerador_janela at 4x4; define GERADOR_SOF_EN to cover sof_in
module tb_gerador_janela;

  localparam int W = 4;
  localparam int H = 4;
  localparam logic [71:0] FIRST_WIN = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
  localparam logic [71:0] LAST_WIN  = {8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6};
  localparam logic [71:0] F2_WIN    = {8'd111, 8'd110, 8'd109, 8'd107, 8'd106, 8'd105, 8'd103, 8'd102, 8'd101};

  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b1;
  logic [7:0]  pixel_in;
  logic        pixel_valid_in;
`ifdef GERADOR_SOF_EN
  logic        sof_in;
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif
  logic [71:0] window_out;
  logic        window_valid_out;

  int checks = 0;
  int errors = 0;

  gerador_janela #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .pixel_in         (pixel_in),
    .pixel_valid_in   (pixel_valid_in),
`ifdef GERADOR_SOF_EN
    .sof_in           (sof_in),
`endif
    .window_out       (window_out),
    .window_valid_out (window_valid_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0]  pix;
    logic        exp_valid;
    logic [71:0] exp_win;
  } vec_t;

  vec_t        tbl [W*H];
  logic [7:0]  img [H][W];
  int          m_row, m_col;
  logic        m_valid;
  logic [71:0] m_win;
  logic [71:0] got [$];
  logic [71:0] ref_wins [$];

  function automatic logic [7:0] ramp(input int r, input int c, input int base);
    return 8'(W*r + c + 1 + base);
  endfunction

  function automatic logic [71:0] ramp_win(input int r, input int c, input int base);
    logic [71:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[(dr*3 + dc)*8 +: 8] = ramp(r - 2 + dr, c - 2 + dc, base);
    return w;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_row   = 0;
    m_col   = 0;
    m_valid = 1'b0;
    m_win   = '0;
  endtask

  // One clock: drive, let the edge happen, advance the image-level model, compare
  task automatic step(input logic [7:0] pix, input logic v, input logic s);
    pixel_in       = pix;
    pixel_valid_in = v;
`ifdef GERADOR_SOF_EN
    sof_in = s;
`endif
    @(posedge clk_in);
    #1;
    m_valid = 1'b0;
    if (v) begin
      if (s && SOF_EN) begin
        m_row = 0;
        m_col = 0;
      end
      img[m_row][m_col] = pix;
      if (m_row >= 2 && m_col >= 2) begin
        m_valid = 1'b1;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            m_win[(dr*3 + dc)*8 +: 8] = img[m_row - 2 + dr][m_col - 2 + dc];
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    check("valid", {71'd0, window_valid_out}, {71'd0, m_valid});
    check("window", window_out, m_win);
    if (window_valid_out) got.push_back(window_out);
  endtask

  task automatic do_reset();
    reset_n_in     = 1'b0;
    pixel_valid_in = 1'b0;
    pixel_in       = 8'h00;
`ifdef GERADOR_SOF_EN
    sof_in = 1'b0;
`endif
    #2;
    check("reset_valid", {71'd0, window_valid_out}, 72'd0);
    check("reset_window", window_out, 72'd0);
    @(posedge clk_in);
    #1;
    reset_n_in = 1'b1;
    model_reset();
  endtask

  task automatic send_frame(input int base, input int max_idle, input bit sof, input bit rnd);
    for (int k = 0; k < W*H; k++) begin
      int idle;
      idle = $urandom_range(0, max_idle);
      for (int i = 0; i < idle; i++) step(8'($urandom), 1'b0, 1'($urandom));
      step(rnd ? 8'($urandom) : ramp(k / W, k % W, base), 1'b1, sof && (k == 0));
    end
  endtask

  task automatic compare_ref(input string name);
    check({name, "_count"}, 72'(got.size()), 72'd4);
    for (int i = 0; i < 4; i++) check(name, got[i], ref_wins[i]);
  endtask

  initial begin
    logic [71:0] last;
    pixel_in       = 8'h00;
    pixel_valid_in = 1'b0;
`ifdef GERADOR_SOF_EN
    sof_in = 1'b0;
`endif
    #2;
    do_reset();

    last = '0;
    for (int k = 0; k < W*H; k++) begin
      tbl[k].pix       = ramp(k / W, k % W, 0);
      tbl[k].exp_valid = (k / W >= 2) && (k % W >= 2);
      if (tbl[k].exp_valid) last = ramp_win(k / W, k % W, 0);
      tbl[k].exp_win   = last;
    end

    got.delete();
    for (int k = 0; k < W*H; k++) begin
      step(tbl[k].pix, 1'b1, 1'b0);
      check("tbl_valid", {71'd0, window_valid_out}, {71'd0, tbl[k].exp_valid});
      check("tbl_window", window_out, tbl[k].exp_win);
    end
    check("frame1_count", 72'(got.size()), 72'd4);
    check("first_window", got[0], FIRST_WIN);
    check("last_window", got[got.size() - 1], LAST_WIN);
    ref_wins = got;

    do_reset();
    got.delete();
    send_frame(0, 3, 1'b0, 1'b0);
    compare_ref("idle_gaps");

    got.delete();
    send_frame(0, 0, 1'b0, 1'b0);
    send_frame(100, 0, 1'b0, 1'b0);
    check("two_frames_count", 72'(got.size()), 72'd8);
    check("frame2_first", got[4], F2_WIN);

    for (int k = 0; k < 9; k++) step(ramp(k / W, k % W, 0), 1'b1, 1'b0);
    do_reset();
    got.delete();
    send_frame(0, 1, 1'b0, 1'b0);
    compare_ref("after_reset");

`ifdef GERADOR_SOF_EN
    for (int k = 0; k < 5; k++) step(8'($urandom), 1'b1, 1'b0);
    got.delete();
    send_frame(0, 0, 1'b1, 1'b0);
    compare_ref("sof_resync");
    step(8'hAA, 1'b0, 1'b1);
`endif

    do_reset();
    for (int f = 0; f < 3; f++) send_frame(0, 2, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
